// File: rtl/pong_pkg.sv
// Shared Pong constants: match state encoding, object sizes and screen bounds,
// so the match controller, movement and graphics blocks agree on them.
package pong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_POINT = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  localparam int BALL_SIZE     = 8;
  localparam int PADDLE_LENGTH = 64;
  localparam int SCREEN_X_MAX  = 639;
  localparam int SCREEN_Y_MAX  = 479;

  // The ball is held centred whenever the match is not actively being played or frozen.
  function automatic logic restart_for(input state_e st);
    return (st == ST_IDLE) || (st == ST_SERVE) || (st == ST_OVER);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// One-bit rising-edge detector: registers the previous input value and
// pulses for one clk when the input is high and was low on the previous clk.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic in_i,
  output logic rise_o
);

  logic prev_q;

  // History register, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= in_i;
    end
  end

  assign rise_o = in_i & ~prev_q;

endmodule

// File: rtl/pong_match_controller.sv
// Match sequencer for Pong: serve / play / point-freeze / game-over flow,
// score and rally bookkeeping, all paced by the VGA end-of-frame strobe.
module pong_match_controller
  import pong_pkg::*;
#(
  parameter int WIN_SCORE    = 7,
  parameter int SERVE_FRAMES = 60,
  parameter int POINT_FRAMES = 90,
  parameter int RALLY_W      = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               endofframe,
  input  logic               start_btn,
  input  logic               collided,
  input  logic               miss_one,
  input  logic               miss_two,
  output logic               restart,
  output logic               play_en,
  output logic [3:0]         score_one,
  output logic [3:0]         score_two,
  output logic [RALLY_W-1:0] rally,
  output logic               game_over,
  output logic               winner,
  output logic [2:0]         state_o
);

  localparam int MAX_FRAMES = (SERVE_FRAMES > POINT_FRAMES) ? SERVE_FRAMES : POINT_FRAMES;
  localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

  localparam logic [CNT_W-1:0]   SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0]   POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
  localparam logic [3:0]         WIN_VAL    = 4'(WIN_SCORE);
  localparam logic [RALLY_W-1:0] RALLY_MAX  = {RALLY_W{1'b1}};
  localparam logic [RALLY_W-1:0] RALLY_ONE  = RALLY_W'(1);

  logic frame_tick_s;
  logic start_press_s;

  state_e             state_q,     state_d;
  logic [CNT_W-1:0]   frames_q,    frames_d;
  logic [3:0]         score_one_q, score_one_d;
  logic [3:0]         score_two_q, score_two_d;
  logic [RALLY_W-1:0] rally_q,     rally_d;
  logic               winner_q,    winner_d;
  logic               restart_q,   restart_d;
  logic               play_en_q,   play_en_d;
  logic               game_over_q, game_over_d;

  rise_detect u_frame_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (endofframe),
    .rise_o (frame_tick_s)
  );

  rise_detect u_start_edge (
    .clk    (clk),
    .reset  (reset),
    .in_i   (start_btn),
    .rise_o (start_press_s)
  );

  // Match state, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      frames_q    <= '0;
      score_one_q <= 4'd0;
      score_two_q <= 4'd0;
      rally_q     <= '0;
      winner_q    <= 1'b0;
      restart_q   <= 1'b1;
      play_en_q   <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frames_q    <= frames_d;
      score_one_q <= score_one_d;
      score_two_q <= score_two_d;
      rally_q     <= rally_d;
      winner_q    <= winner_d;
      restart_q   <= restart_d;
      play_en_q   <= play_en_d;
      game_over_q <= game_over_d;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they line up with state_o.
  always_comb begin
    state_d     = state_q;
    frames_d    = frames_q;
    score_one_d = score_one_q;
    score_two_d = score_two_q;
    rally_d     = rally_q;
    winner_d    = winner_q;

    case (state_q)
      ST_IDLE: begin
        if (start_press_s) begin
          score_one_d = 4'd0;
          score_two_d = 4'd0;
          rally_d     = '0;
          frames_d    = '0;
          state_d     = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (frame_tick_s) begin
          if (frames_q == SERVE_LAST) begin
            frames_d = '0;
            state_d  = ST_PLAY;
          end else begin
            frames_d = frames_q + CNT_ONE;
          end
        end
      end
      ST_PLAY: begin
        // A miss outranks a same-frame paddle hit; a double miss scores nobody.
        if (frame_tick_s) begin
          if (miss_one && miss_two) begin
            state_d = ST_POINT;
          end else if (miss_one) begin
            score_two_d = score_two_q + 4'd1;
            state_d     = ST_POINT;
          end else if (miss_two) begin
            score_one_d = score_one_q + 4'd1;
            state_d     = ST_POINT;
          end else if (collided && (rally_q != RALLY_MAX)) begin
            rally_d = rally_q + RALLY_ONE;
          end
        end
      end
      ST_POINT: begin
        if (frame_tick_s) begin
          if (frames_q == POINT_LAST) begin
            frames_d = '0;
            if (score_one_q == WIN_VAL) begin
              winner_d = 1'b0;
              state_d  = ST_OVER;
            end else if (score_two_q == WIN_VAL) begin
              winner_d = 1'b1;
              state_d  = ST_OVER;
            end else begin
              rally_d = '0;
              state_d = ST_SERVE;
            end
          end else begin
            frames_d = frames_q + CNT_ONE;
          end
        end
      end
      ST_OVER: begin
        if (start_press_s) begin
          score_one_d = 4'd0;
          score_two_d = 4'd0;
          rally_d     = '0;
          winner_d    = 1'b0;
          frames_d    = '0;
          state_d     = ST_SERVE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    restart_d   = restart_for(state_d);
    play_en_d   = (state_d == ST_PLAY);
    game_over_d = (state_d == ST_OVER);
  end

  assign restart   = restart_q;
  assign play_en   = play_en_q;
  assign score_one = score_one_q;
  assign score_two = score_two_q;
  assign rally     = rally_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Randomized bench for pong_match_controller against a frame-level match model.
module tb_pong_match_controller;

  localparam int WIN_SCORE    = 2;
  localparam int SERVE_FRAMES = 4;
  localparam int POINT_FRAMES = 3;
  localparam int RALLY_W      = 3;
  localparam int RALLY_TOP    = (1 << RALLY_W) - 1;

  localparam int M_IDLE  = 0;
  localparam int M_SERVE = 1;
  localparam int M_PLAY  = 2;
  localparam int M_POINT = 3;
  localparam int M_OVER  = 4;

  logic clk = 1'b0;
  logic reset, endofframe, start_btn, collided, miss_one, miss_two;
  logic restart, play_en, game_over, winner;
  logic [3:0] score_one, score_two;
  logic [RALLY_W-1:0] rally;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  int m_state, m_s1, m_s2, m_rally, m_frames, m_win;
  bit m_prev_eof, m_prev_btn;
  int eof_left, rst_left;

  always #5 clk = ~clk;

  pong_match_controller #(
    .WIN_SCORE    (WIN_SCORE),
    .SERVE_FRAMES (SERVE_FRAMES),
    .POINT_FRAMES (POINT_FRAMES),
    .RALLY_W      (RALLY_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .endofframe (endofframe),
    .start_btn  (start_btn),
    .collided   (collided),
    .miss_one   (miss_one),
    .miss_two   (miss_two),
    .restart    (restart),
    .play_en    (play_en),
    .score_one  (score_one),
    .score_two  (score_two),
    .rally      (rally),
    .game_over  (game_over),
    .winner     (winner),
    .state_o    (state_o)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Effect of one clock edge on the match, given the inputs currently driven.
  task automatic model_step();
    bit tick, press;
    if (reset) begin
      m_state = M_IDLE; m_s1 = 0; m_s2 = 0; m_rally = 0; m_frames = 0; m_win = 0;
      m_prev_eof = 1'b0; m_prev_btn = 1'b0;
      return;
    end
    tick = endofframe && !m_prev_eof;
    press = start_btn && !m_prev_btn;
    m_prev_eof = endofframe;
    m_prev_btn = start_btn;
    case (m_state)
      M_IDLE, M_OVER: if (press) begin
        m_s1 = 0; m_s2 = 0; m_rally = 0; m_win = 0; m_frames = 0; m_state = M_SERVE;
      end
      M_SERVE: if (tick) begin
        m_frames++;
        if (m_frames == SERVE_FRAMES) begin m_frames = 0; m_state = M_PLAY; end
      end
      M_PLAY: if (tick) begin
        if (miss_one || miss_two) begin
          if (miss_one && !miss_two) m_s2++;
          if (miss_two && !miss_one) m_s1++;
          m_state = M_POINT;
        end else if (collided) begin
          m_rally = (m_rally < RALLY_TOP) ? m_rally + 1 : RALLY_TOP;
        end
      end
      M_POINT: if (tick) begin
        m_frames++;
        if (m_frames == POINT_FRAMES) begin
          m_frames = 0;
          if (m_s1 == WIN_SCORE || m_s2 == WIN_SCORE) begin
            m_win = (m_s1 == WIN_SCORE) ? 0 : 1;
            m_state = M_OVER;
          end else begin
            m_rally = 0;
            m_state = M_SERVE;
          end
        end
      end
      default: m_state = M_IDLE;
    endcase
  endtask

  task automatic check_all();
    check_val("state",     32'(state_o),   32'(m_state));
    check_val("restart",   32'(restart),   32'(m_state == M_IDLE || m_state == M_SERVE || m_state == M_OVER));
    check_val("play_en",   32'(play_en),   32'(m_state == M_PLAY));
    check_val("game_over", 32'(game_over), 32'(m_state == M_OVER));
    check_val("winner",    32'(winner),    32'(m_win));
    check_val("score_one", 32'(score_one), 32'(m_s1));
    check_val("score_two", 32'(score_two), 32'(m_s2));
    check_val("rally",     32'(rally),     32'(m_rally));
  endtask

  task automatic drive_random();
    if (rst_left > 0) begin
      rst_left--;
    end else if ($urandom_range(0, 1499) == 0) begin
      rst_left = $urandom_range(1, 3);
    end
    reset = (rst_left > 0);
    if (eof_left == 0) begin
      endofframe = ~endofframe;
      eof_left = endofframe ? $urandom_range(1, 3) : $urandom_range(2, 6);
    end else begin
      eof_left--;
    end
    start_btn = ($urandom_range(0, 7) == 0);
    collided  = ($urandom_range(0, 3) != 0);
    miss_one  = ($urandom_range(0, 9) == 0);
    miss_two  = ($urandom_range(0, 9) == 0);
  endtask

  initial begin
    reset = 1'b1; endofframe = 1'b1; start_btn = 1'b0;
    collided = 1'b0; miss_one = 1'b0; miss_two = 1'b0;
    eof_left = 6; rst_left = 0;
    model_step();
    for (int cyc = 0; cyc < 8000; cyc++) begin
      @(negedge clk);
      check_all();
      if (cyc < 3) begin
        reset = 1'b1;
      end else begin
        drive_random();
      end
      model_step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
